cnn_sram_responder: RTL and testbench
=====================================

CNN_SRAM_RESPONDER -- requirements
Module: cnn_sram_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_LEN, 32, element width in bits.
- N, 8, elements per word; word width W = DATA_LEN*N.
- ADDRESS_SIZE, 10, word address width; depth = 2**ADDRESS_SIZE.
REQ-002 The ports SHALL be, one per line:
- i_clk  in  1  single clock.
- i_rstn  in  1  reset; synchronous, active-low (fixed: one clock, synchronous active-low reset).
- i_address  in  ADDRESS_SIZE  accelerator-port word address.
- i_clken  in  1  accelerator-port clock enable.
- i_chipselect  in  1  accelerator-port select.
- i_write  in  1  accelerator-port write strobe.
- i_writedata  in  W  accelerator-port write data.
- i_byteenable  in  W/8  accelerator-port byte lanes.
- o_readdata  out  W  accelerator-port read data.
- i_h_address  in  ADDRESS_SIZE  host-port word address.
- i_h_read  in  1  host-port read request.
- i_h_write  in  1  host-port write request.
- i_h_writedata  in  W  host-port write data.
- i_h_byteenable  in  W/8  host-port byte lanes.
- o_h_waitrequest  out  1  host-port stall.
- o_h_readdata  out  W  host-port read data.
- o_h_readdatavalid  out  1  host-port read data qualifier.

Function
REQ-003 The block SHALL be the memory responder for the matrix-ops controller: one shared single-port array, an accelerator port with fixed latency and no stall, and a host port with waitrequest.
REQ-004 An accelerator access SHALL occur in a cycle when i_clken=1 and i_chipselect=1; when i_clken=0, the accelerator port SHALL hold o_readdata and perform no access.
REQ-005 An accelerator write SHALL update only the byte lanes whose i_byteenable bit is 1.
REQ-006 An accelerator access with i_write=0 SHALL be a read; o_readdata SHALL present the word at the rising edge LAT cycles later.
REQ-007 LAT SHALL be 1 by default.
REQ-008 A read to the address being written in the same cycle SHALL return the old data (read-before-write).
REQ-009 Arbitration SHALL use fixed priority: an accelerator access always wins.
REQ-010 A host request (i_h_read or i_h_write) in the same cycle as an accelerator access SHALL be stalled with o_h_waitrequest=1, combinationally.
REQ-011 A host request SHALL be accepted in the first cycle with no accelerator access; o_h_waitrequest SHALL be 0 in that cycle.
REQ-012 The host SHALL hold its request stable while o_h_waitrequest=1.
REQ-013 i_h_read=1 together with i_h_write=1 SHALL be treated as a write.
REQ-014 An accepted host read SHALL assert o_h_readdatavalid for exactly one cycle, LAT cycles after acceptance, with o_h_readdata valid in that cycle.
REQ-015 o_h_readdata SHALL hold its last value otherwise.
REQ-016 Back-to-back accepted host reads SHALL produce one valid per cycle, in order.
REQ-017 A host write accepted in cycle t SHALL be visible to any read issued in cycle t+1 or later.
REQ-018 An address at or beyond depth SHALL be impossible by construction; address width equals the array index width.

Reset
REQ-019 While i_rstn=0 at a rising edge:
- o_readdata, o_h_readdata and o_h_readdatavalid SHALL be 0.
- The read pipeline SHALL be flushed.
- No write SHALL occur.
REQ-020 Array contents SHALL be unchanged by reset.
REQ-021 A host read accepted before reset whose data is not yet returned SHALL be dropped; no valid is issued after reset.
REQ-022 o_h_waitrequest SHALL be 1 while i_rstn=0.

Configuration
REQ-023 With macro CNN_SRAM_OUTREG_EN defined, an extra output register stage SHALL be added on both read ports, making LAT=2 on both ports.
REQ-024 Without CNN_SRAM_OUTREG_EN, LAT SHALL be 1.
REQ-025 Arbitration and write behaviour SHALL be identical in both builds.

Structure
REQ-026 DATA_LEN, N and ADDRESS_SIZE defaults SHALL come from the shared defines package; that package SHALL also hold the LAT constant derived from CNN_SRAM_OUTREG_EN.
REQ-027 The byte-lane write mask generation SHALL be one sub-module, sram_byte_merge, instantiated once after the arbiter.

Verification
REQ-028 Accelerator write 0xA5 in all 32 bytes at address 3, then read address 3 -> o_readdata equals that word LAT cycles after the read.
REQ-029 Write all-ones at address 5, then write 0 with i_byteenable=0x0000000F -> a read of address 5 returns the low 4 bytes 0 and all other bytes 0xFF.
REQ-030 Host read of address 7 in the same cycle as an accelerator read, accelerator active 3 cycles -> o_h_waitrequest=1 for 3 cycles; accepted in cycle 4; o_h_readdatavalid pulses once at cycle 4+LAT.
REQ-031 In the same cycle, accelerator writes 0x1 to address 9 and host writes 0x2 to address 9 -> host stalled one cycle, then its write completes; final read returns 0x2.
REQ-032 Host read accepted, then i_rstn=0 asserted the next cycle -> o_h_readdatavalid stays 0 and outputs are 0.
REQ-033 Array data written before reset reads back unchanged after reset.

Source files
------------

// File: rtl/cnn_sram_responder_pkg.sv
// ----------------------------------------------------------------------------
// cnn_sram_responder_pkg
// Shared defines for the matrix-ops memory responder: default geometry of the
// word array, the read latency of both ports, and the arbiter grant encoding.
//
// Build option: CNN_SRAM_OUTREG_EN
//   undefined -> read latency 1 (array read register drives the outputs)
//   defined   -> read latency 2 (one extra output register on both ports)
// ----------------------------------------------------------------------------
package cnn_sram_responder_pkg;

  localparam int DATA_LEN_DEF     = 32;  // element width in bits
  localparam int N_DEF            = 8;   // elements per word
  localparam int ADDRESS_SIZE_DEF = 10;  // word address width

`ifdef CNN_SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // Owner of the single array port in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_ACC  = 2'd1,
    GRANT_HOST = 2'd2
  } grant_e;

  // Number of byte lanes in a word of dl*n bits.
  function automatic int byte_lanes(input int dl, input int n);
    return (dl * n) / 8;
  endfunction

endpackage

// File: rtl/cnn_sram_responder_byte_merge.sv
// ----------------------------------------------------------------------------
// sram_byte_merge
// Turns the granted write strobe and byte-enable mask into one write enable
// per byte lane of the array word.
//
// Ports:
//   we         in  1   granted write strobe (already qualified by arbiter)
//   byteenable in  NB  byte lanes of the granted request
//   lane_we    out NB  per-lane write enable into the array
// ----------------------------------------------------------------------------
module sram_byte_merge #(
  parameter int NB = 32
) (
  input  logic          we,
  input  logic [NB-1:0] byteenable,
  output logic [NB-1:0] lane_we
);

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane_we[gi] = we & byteenable[gi];
    end
  endgenerate

endmodule

// File: rtl/cnn_sram_responder.sv
// ----------------------------------------------------------------------------
// cnn_sram_responder
// Memory responder for the matrix-ops controller. One single-port word array
// is shared by an accelerator port (fixed latency, never stalls) and a host
// port (waitrequest/readdatavalid). The accelerator always wins; a host
// request seen in the same cycle is stalled combinationally and retried by
// the host until a cycle with no accelerator access.
//
// Build option: CNN_SRAM_OUTREG_EN adds one output register on both read
// ports (LAT = 2); without it LAT = 1.
//
// Ports:
//   i_clk, i_rstn            clock, synchronous active-low reset
//   i_address .. i_byteenable accelerator request (access when clken & cs)
//   o_readdata                accelerator read data, LAT cycles after read
//   i_h_address .. i_h_byteenable host request (read+write acts as write)
//   o_h_waitrequest           host stall (also held high during reset)
//   o_h_readdata              host read data, held between valids
//   o_h_readdatavalid         one-cycle qualifier per accepted host read
// ----------------------------------------------------------------------------
module cnn_sram_responder
  import cnn_sram_responder_pkg::*;
#(
  parameter int DATA_LEN     = DATA_LEN_DEF,
  parameter int N            = N_DEF,
  parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [ADDRESS_SIZE-1:0]   i_address,
  input  logic                      i_clken,
  input  logic                      i_chipselect,
  input  logic                      i_write,
  input  logic [DATA_LEN*N-1:0]     i_writedata,
  input  logic [DATA_LEN*N/8-1:0]   i_byteenable,
  output logic [DATA_LEN*N-1:0]     o_readdata,
  input  logic [ADDRESS_SIZE-1:0]   i_h_address,
  input  logic                      i_h_read,
  input  logic                      i_h_write,
  input  logic [DATA_LEN*N-1:0]     i_h_writedata,
  input  logic [DATA_LEN*N/8-1:0]   i_h_byteenable,
  output logic                      o_h_waitrequest,
  output logic [DATA_LEN*N-1:0]     o_h_readdata,
  output logic                      o_h_readdatavalid
);

  localparam int W     = DATA_LEN * N;
  localparam int NB    = byte_lanes(DATA_LEN, N);
  localparam int DEPTH = 1 << ADDRESS_SIZE;

  // Address width equals the index width, so out-of-range is unreachable.
  logic [W-1:0] mem [DEPTH];

  logic                    acc_access;
  logic                    host_req;
  grant_e                  grant;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [W-1:0]            mem_wdata;
  logic [NB-1:0]           mem_be;
  logic                    mem_we;
  logic [NB-1:0]           lane_we;
  logic                    acc_rd;
  logic                    host_rd;

  logic [W-1:0]            acc_q_reg;
  logic [W-1:0]            host_q_reg;
  logic                    host_vld_reg;

  assign acc_access = i_clken & i_chipselect;
  assign host_req   = i_h_read | i_h_write;

  // Fixed-priority arbiter; nothing is granted while reset is asserted so
  // no write can land during reset.
  always_comb begin
    grant     = GRANT_NONE;
    mem_addr  = i_h_address;
    mem_wdata = i_h_writedata;
    mem_be    = i_h_byteenable;
    mem_we    = 1'b0;
    if (i_rstn) begin
      if (acc_access) begin
        grant     = GRANT_ACC;
        mem_addr  = i_address;
        mem_wdata = i_writedata;
        mem_be    = i_byteenable;
        mem_we    = i_write;
      end else if (host_req) begin
        grant     = GRANT_HOST;
        mem_we    = i_h_write;   // read+write together resolves to a write
      end
    end
  end

  assign acc_rd  = (grant == GRANT_ACC)  & ~i_write;
  assign host_rd = (grant == GRANT_HOST) & ~i_h_write;

  // The host only has to look at the accelerator strobe to know it lost.
  assign o_h_waitrequest = ~i_rstn | acc_access;

  sram_byte_merge #(
    .NB(NB)
  ) u_byte_merge (
    .we        (mem_we),
    .byteenable(mem_be),
    .lane_we   (lane_we)
  );

  // Array write, byte-lane granular. Array contents are never reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (lane_we[b]) begin
        mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Registered read. Non-blocking semantics give read-before-write on a
  // same-address collision. Each port keeps its own capture register so it
  // holds its last value across cycles it does not own the array.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      acc_q_reg    <= '0;
      host_q_reg   <= '0;
      host_vld_reg <= 1'b0;
    end else begin
      host_vld_reg <= host_rd;
      if (acc_rd) begin
        acc_q_reg <= mem[mem_addr];
      end
      if (host_rd) begin
        host_q_reg <= mem[mem_addr];
      end
    end
  end

`ifdef CNN_SRAM_OUTREG_EN
  logic         acc_vld_reg;
  logic [W-1:0] acc_out_reg;
  logic [W-1:0] host_out_reg;
  logic         host_vld_out_reg;

  // Second stage only moves when the first stage captured new data, so both
  // ports still hold between reads.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      acc_vld_reg      <= 1'b0;
      acc_out_reg      <= '0;
      host_out_reg     <= '0;
      host_vld_out_reg <= 1'b0;
    end else begin
      acc_vld_reg      <= acc_rd;
      host_vld_out_reg <= host_vld_reg;
      if (acc_vld_reg) begin
        acc_out_reg <= acc_q_reg;
      end
      if (host_vld_reg) begin
        host_out_reg <= host_q_reg;
      end
    end
  end

  assign o_readdata        = acc_out_reg;
  assign o_h_readdata      = host_out_reg;
  assign o_h_readdatavalid = host_vld_out_reg;
`else
  assign o_readdata        = acc_q_reg;
  assign o_h_readdata      = host_q_reg;
  assign o_h_readdatavalid = host_vld_reg;
`endif

endmodule

// File: tb/tb_cnn_sram_responder.sv
module tb_cnn_sram_responder;
  import cnn_sram_responder_pkg::*;

  localparam int W  = 256;
  localparam int NB = 32;
  localparam int AW = 10;
  localparam int NV = 14;

  logic          i_clk;
  logic          i_rstn;
  logic [AW-1:0] i_address;
  logic          i_clken;
  logic          i_chipselect;
  logic          i_write;
  logic [W-1:0]  i_writedata;
  logic [NB-1:0] i_byteenable;
  logic [W-1:0]  o_readdata;
  logic [AW-1:0] i_h_address;
  logic          i_h_read;
  logic          i_h_write;
  logic [W-1:0]  i_h_writedata;
  logic [NB-1:0] i_h_byteenable;
  logic          o_h_waitrequest;
  logic [W-1:0]  o_h_readdata;
  logic          o_h_readdatavalid;

  cnn_sram_responder dut (
    .i_clk            (i_clk),
    .i_rstn           (i_rstn),
    .i_address        (i_address),
    .i_clken          (i_clken),
    .i_chipselect     (i_chipselect),
    .i_write          (i_write),
    .i_writedata      (i_writedata),
    .i_byteenable     (i_byteenable),
    .o_readdata       (o_readdata),
    .i_h_address      (i_h_address),
    .i_h_read         (i_h_read),
    .i_h_write        (i_h_write),
    .i_h_writedata    (i_h_writedata),
    .i_h_byteenable   (i_h_byteenable),
    .o_h_waitrequest  (o_h_waitrequest),
    .o_h_readdata     (o_h_readdata),
    .o_h_readdatavalid(o_h_readdatavalid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          clken;
    logic          cs;
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [NB-1:0] be;
    logic          h_rd;
    logic          h_wr;
    logic [AW-1:0] h_addr;
    logic [W-1:0]  h_wdata;
    logic [NB-1:0] h_be;
    logic          exp_wait;
    logic [W-1:0]  exp_rd;
    logic [W-1:0]  exp_hrd;
    logic          exp_hv;
  } vec_t;

  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]  a5w;
  logic [W-1:0]  m5;
  logic [W-1:0]  ones;
  logic [W-1:0]  w1234;
  logic [W-1:0]  w77;
  logic [NB-1:0] be_all;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    i_clken        = 1'b0;
    i_chipselect   = 1'b0;
    i_write        = 1'b0;
    i_address      = '0;
    i_writedata    = '0;
    i_byteenable   = '0;
    i_h_read       = 1'b0;
    i_h_write      = 1'b0;
    i_h_address    = '0;
    i_h_writedata  = '0;
    i_h_byteenable = '0;
  endtask

  task automatic apply(input vec_t v);
    i_clken        = v.clken;
    i_chipselect   = v.cs;
    i_write        = v.wr;
    i_address      = v.addr;
    i_writedata    = v.wdata;
    i_byteenable   = v.be;
    i_h_read       = v.h_rd;
    i_h_write      = v.h_wr;
    i_h_address    = v.h_addr;
    i_h_writedata  = v.h_wdata;
    i_h_byteenable = v.h_be;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    a5w    = {32{8'hA5}};
    ones   = {W{1'b1}};
    m5     = {{28{8'hFF}}, 32'h0};
    w1234  = 256'h1234;
    w77    = 256'h77;
    be_all = {NB{1'b1}};

    //          clk cs wr addr   wdata  be          hrd hwr haddr  hwdata  hbe     wait rd     hrd    hv
    vecs[0]  = '{1, 1, 1, 10'd3,  a5w,   be_all,     0, 0, 10'd0,  '0,     '0,     0,   '0,    '0,    0};
    vecs[1]  = '{1, 1, 0, 10'd3,  '0,    '0,         0, 0, 10'd0,  '0,     '0,     0,   a5w,   '0,    0};
    vecs[2]  = '{1, 1, 1, 10'd5,  ones,  be_all,     0, 0, 10'd0,  '0,     '0,     0,   a5w,   '0,    0};
    vecs[3]  = '{1, 1, 1, 10'd5,  '0,    32'h0000000F, 0, 0, 10'd0, '0,    '0,     0,   a5w,   '0,    0};
    vecs[4]  = '{1, 1, 0, 10'd5,  '0,    '0,         0, 0, 10'd0,  '0,     '0,     0,   m5,    '0,    0};
    vecs[5]  = '{0, 0, 0, 10'd0,  '0,    '0,         0, 1, 10'd10, w1234,  be_all, 0,   m5,    '0,    0};
    vecs[6]  = '{0, 0, 0, 10'd0,  '0,    '0,         1, 0, 10'd10, '0,     '0,     0,   m5,    w1234, 1};
    vecs[7]  = '{1, 1, 0, 10'd5,  '0,    '0,         1, 0, 10'd3,  '0,     '0,     1,   m5,    w1234, 0};
    vecs[8]  = '{0, 0, 0, 10'd0,  '0,    '0,         1, 0, 10'd3,  '0,     '0,     0,   m5,    a5w,   1};
    vecs[9]  = '{0, 0, 0, 10'd0,  '0,    '0,         1, 0, 10'd5,  '0,     '0,     0,   m5,    m5,    1};
    vecs[10] = '{1, 1, 0, 10'd10, '0,    '0,         0, 0, 10'd0,  '0,     '0,     0,   w1234, m5,    0};
    vecs[11] = '{0, 1, 0, 10'd3,  '0,    '0,         0, 0, 10'd0,  '0,     '0,     0,   w1234, m5,    0};
    vecs[12] = '{0, 0, 0, 10'd0,  '0,    '0,         1, 1, 10'd11, w77,    be_all, 0,   w1234, m5,    0};
    vecs[13] = '{1, 1, 0, 10'd11, '0,    '0,         0, 0, 10'd0,  '0,     '0,     0,   w77,   m5,    0};

    // Reset state
    idle();
    i_rstn = 1'b0;
    #1;
    chk("wait_in_reset_comb", o_h_waitrequest, 1'b1);
    repeat (3) tick();
    chk("reset_readdata", o_readdata, '0);
    chk("reset_h_readdata", o_h_readdata, '0);
    chk("reset_h_valid", o_h_readdatavalid, 1'b0);
    chk("reset_wait", o_h_waitrequest, 1'b1);
    i_rstn = 1'b1;
    tick();

    // Table: vector i's registered results are checked LAT edges later
    for (int i = 0; i < NV + LAT - 1; i++) begin
      if (i < NV) apply(vecs[i]);
      else        idle();
      #1;
      if (i < NV && (vecs[i].h_rd || vecs[i].h_wr))
        chk($sformatf("v%0d_wait", i), o_h_waitrequest, vecs[i].exp_wait);
      tick();
      if (i + 1 - LAT >= 0 && i + 1 - LAT < NV) begin
        chk($sformatf("v%0d_rd", i + 1 - LAT), o_readdata, vecs[i + 1 - LAT].exp_rd);
        chk($sformatf("v%0d_hrd", i + 1 - LAT), o_h_readdata, vecs[i + 1 - LAT].exp_hrd);
        chk($sformatf("v%0d_hv", i + 1 - LAT), o_h_readdatavalid, vecs[i + 1 - LAT].exp_hv);
      end
      $display("vector %0d applied", i);
    end
    idle();
    tick();

    // Host read of address 7 stalled by 3 accelerator cycles
    i_h_write = 1'b1; i_h_address = 10'd7; i_h_writedata = 256'hC0FFEE; i_h_byteenable = be_all;
    #1;
    chk("a7_write_wait", o_h_waitrequest, 1'b0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      i_clken = 1'b1; i_chipselect = 1'b1; i_address = 10'd3;
      i_h_read = 1'b1; i_h_address = 10'd7;
      #1;
      chk($sformatf("stall%0d_wait", k), o_h_waitrequest, 1'b1);
      tick();
      chk($sformatf("stall%0d_hv", k), o_h_readdatavalid, 1'b0);
    end
    i_clken = 1'b0; i_chipselect = 1'b0;
    #1;
    chk("accept_wait", o_h_waitrequest, 1'b0);
    tick();
    idle();
    repeat (LAT - 1) tick();
    chk("a7_hv", o_h_readdatavalid, 1'b1);
    chk("a7_hrd", o_h_readdata, 256'hC0FFEE);
    tick();
    chk("a7_hv_once", o_h_readdatavalid, 1'b0);
    $display("stall sequence done");

    // Accelerator and host write address 9 in the same cycle
    i_clken = 1'b1; i_chipselect = 1'b1; i_write = 1'b1; i_address = 10'd9;
    i_writedata = 256'h1; i_byteenable = be_all;
    i_h_write = 1'b1; i_h_address = 10'd9; i_h_writedata = 256'h2; i_h_byteenable = be_all;
    #1;
    chk("a9_collide_wait", o_h_waitrequest, 1'b1);
    tick();
    i_clken = 1'b0; i_chipselect = 1'b0; i_write = 1'b0;
    #1;
    chk("a9_retry_wait", o_h_waitrequest, 1'b0);
    tick();
    idle();
    i_clken = 1'b1; i_chipselect = 1'b1; i_address = 10'd9;
    tick();
    idle();
    repeat (LAT - 1) tick();
    chk("a9_final", o_readdata, 256'h2);
    $display("collision sequence done");

    // Reset right after an accepted host read
    i_h_read = 1'b1; i_h_address = 10'd3;
    #1;
    chk("pre_rst_wait", o_h_waitrequest, 1'b0);
    tick();
    idle();
    i_rstn = 1'b0;
    #1;
    chk("rst_wait", o_h_waitrequest, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("rst%0d_hv", k), o_h_readdatavalid, 1'b0);
      chk($sformatf("rst%0d_rd", k), o_readdata, '0);
      chk($sformatf("rst%0d_hrd", k), o_h_readdata, '0);
    end
    i_rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst%0d_hv", k), o_h_readdatavalid, 1'b0);
    end
    $display("reset sequence done");

    // Contents survive reset
    i_clken = 1'b1; i_chipselect = 1'b1; i_address = 10'd3;
    tick();
    idle();
    repeat (LAT - 1) tick();
    chk("keep_a3", o_readdata, a5w);
    i_h_read = 1'b1; i_h_address = 10'd9;
    tick();
    idle();
    repeat (LAT - 1) tick();
    chk("keep_a9_hv", o_h_readdatavalid, 1'b1);
    chk("keep_a9_hrd", o_h_readdata, 256'h2);
    $display("retention sequence done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
